// File: rtl/multi_seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with strobe-loaded shadow registers.
// Optional brightness PWM is built only when BRIGHTNESS_PWM_EN is defined.
module multi_seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_COUNT  = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dots,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic                      load,
  input  logic [3:0]                brightness,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int PW = $clog2(DIV_COUNT);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int OW = PW + 1;

  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d, idx_nxt;
  logic [4*NUM_DIGITS-1:0] dig_sh_q, dig_sh_d;
  logic [NUM_DIGITS-1:0]   dot_sh_q, dot_sh_d;
  logic [NUM_DIGITS-1:0]   blk_sh_q, blk_sh_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    slot_blk_q, slot_blk_d;
  logic                    frame_q, frame_d;
  logic                    wrap;
  logic                    an_lit;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;  4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;  4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;  4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
    endcase
  endfunction

  always_comb begin
    wrap       = (pcnt_q == PW'(DIV_COUNT - 1));
    pcnt_d     = wrap ? '0 : pcnt_q + 1'b1;
    idx_nxt    = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    idx_d      = wrap ? idx_nxt : idx_q;
    dig_sh_d   = load ? digits : dig_sh_q;
    dot_sh_d   = load ? dots   : dot_sh_q;
    blk_sh_d   = load ? blank  : blk_sh_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    slot_blk_d = slot_blk_q;
    frame_d    = 1'b0;
    // Slot contents are latched from the pre-edge shadow, so a load on this edge lands one visit later.
    if (wrap) begin
      slot_blk_d = blk_sh_q[idx_nxt];
      frame_d    = (idx_nxt == '0);
      if (blk_sh_q[idx_nxt]) begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end else begin
        seg_d = ~hex7(dig_sh_q[{idx_nxt, 2'b00} +: 4]);
        dp_d  = ~dot_sh_q[idx_nxt];
      end
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  logic [OW-1:0] on_q, on_d;
  logic [31:0]   on_full;

  always_comb begin
    on_full = ((32'(brightness) + 32'd1) * 32'(DIV_COUNT)) >> 4;
    on_d    = on_q;
    if (wrap) on_d = (on_full == 32'd0) ? OW'(1) : OW'(on_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) on_q <= OW'(DIV_COUNT);
    else        on_q <= on_d;
  end

  assign an_lit = (pcnt_q != '0) && ({1'b0, pcnt_q} < on_q) && !slot_blk_q;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign an_lit = (pcnt_q != '0) && !slot_blk_q;
`endif

  // Cycle 0 of each slot keeps every anode off so the previous digit cannot ghost.
  always_comb begin
    an = '1;
    if (an_lit) an[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      dig_sh_q   <= '0;
      dot_sh_q   <= '0;
      blk_sh_q   <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      slot_blk_q <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      dig_sh_q   <= dig_sh_d;
      dot_sh_q   <= dot_sh_d;
      blk_sh_q   <= blk_sh_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      slot_blk_q <= slot_blk_d;
      frame_q    <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_multi_seven_seg_scan.sv
// Scoreboard bench for multi_seven_seg_scan (NUM_DIGITS=4, DIV_COUNT=8): stimulus pushes per-slot
// expectations, a negedge monitor collects each slot's outputs and compares.
module tb_multi_seven_seg_scan;

  localparam int ND  = 4;
  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dots, blank, brightness, an;
  logic        load, dp, frame_done;
  logic [6:0]  seg;

  multi_seven_seg_scan #(.NUM_DIGITS(ND), .DIV_COUNT(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dots(dots), .blank(blank), .load(load),
    .brightness(brightness), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef struct packed {
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] an_v;
    logic [7:0]  fd_v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: gathers one slot (8 negedge samples) and checks it against the queued expectation.
  int          mc = 0;
  logic [6:0]  sseg;
  logic        sdp;
  int          glitch;
  logic [31:0] an_v;
  logic [7:0]  fd_v;
  exp_t        e;

  always @(negedge clk) begin
    if (!mon_en) begin
      mc = 0;
    end else begin
      int c;
      c = mc % DIV;
      if (c == 0) begin
        sseg = seg; sdp = dp; glitch = 0;
      end else if (seg !== sseg || dp !== sdp) begin
        glitch++;
      end
      an_v[4*c +: 4] = an;
      fd_v[c]        = frame_done;
      if (c == DIV - 1) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("seg", {25'd0, sseg}, {25'd0, e.seg});
          chk("dp", {31'd0, sdp}, {31'd0, e.dp});
          chk("seg_dp_stable", glitch, 32'd0);
          chk("an_pattern", an_v, e.an_v);
          chk("frame_done", {24'd0, fd_v}, {24'd0, e.fd_v});
        end
      end
      mc++;
    end
  end

  // Reference model state
  logic [15:0] m_dig;
  logic [3:0]  m_dot, m_blk;
  int          m_idx, m_on;
  bit          m_first;
  bit          pend;
  logic [15:0] p_dig;
  logic [3:0]  p_dot, p_blk;

  function automatic int on_of(input logic [3:0] b);
    int v;
`ifdef BRIGHTNESS_PWM_EN
    v = ((int'(b) + 1) * DIV) >> 4;
    if (v < 1) v = 1;
`else
    v = DIV;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_dig = '0; m_dot = '0; m_blk = 4'hF;
    m_idx = 0; m_on = DIV; m_first = 1'b1; pend = 1'b0;
  endtask

  task automatic push_expect();
    exp_t x;
    logic [3:0] nib;
    logic [3:0] a_on;
    bit bl;
    bl  = m_blk[m_idx];
    nib = m_dig[4*m_idx +: 4];
    a_on = 4'hF;
    a_on[m_idx] = 1'b0;
    x.seg  = bl ? 7'h7F : ~HEX[nib];
    x.dp   = bl ? 1'b1 : ~m_dot[m_idx];
    x.fd_v = 8'h00;
    x.fd_v[0] = (m_idx == 0) && !m_first;
    for (int c = 0; c < DIV; c++)
      x.an_v[4*c +: 4] = (c >= 1 && c < m_on && !bl) ? a_on : 4'hF;
    exp_q.push_back(x);
  endtask

  // One display slot; caller is at posedge+1 of slot cycle 0.
  task automatic run_slot(input bit ld, input int lc, input logic [15:0] d,
                          input logic [3:0] dt, input logic [3:0] bl, input logic [3:0] br);
    push_expect();
    if (pend) begin
      m_dig = p_dig; m_dot = p_dot; m_blk = p_blk; pend = 1'b0;
    end
    brightness = br;
    for (int c = 0; c < DIV; c++) begin
      if (ld && c == lc) begin
        digits = d; dots = dt; blank = bl; load = 1'b1;
      end
      @(posedge clk); #1;
      load = 1'b0;
      if (ld && c == lc) begin
        if (c == DIV - 1) begin
          pend = 1'b1; p_dig = d; p_dot = dt; p_blk = bl;
        end else begin
          m_dig = d; m_dot = dt; m_blk = bl;
        end
      end
    end
    m_on    = on_of(brightness);
    m_idx   = (m_idx + 1) % ND;
    m_first = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; digits = 16'h0; dots = 4'h0; blank = 4'h0; brightness = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_frame", {31'd0, frame_done}, 32'd0);
    release_reset();

    for (int s = 0; s < 32; s++) begin
      case (s)
        7:  run_slot(1'b1, 2, 16'h1A3F, 4'b0100, 4'b0000, 4'hF);
        11: run_slot(1'b1, 2, 16'h1A3F, 4'b0100, 4'b1010, 4'hF);
        14: run_slot(1'b1, 4, 16'h163F, 4'b0100, 4'b1010, 4'hF);
        17: run_slot(1'b1, 7, 16'h1C3F, 4'b0100, 4'b1010, 4'hF);
        default: begin
          if (s >= 23 && s < 27)      run_slot(1'b0, 0, 16'h0, 4'h0, 4'h0, 4'd7);
          else if (s >= 27 && s < 31) run_slot(1'b0, 0, 16'h0, 4'h0, 4'h0, 4'd1);
          else                        run_slot(1'b0, 0, 16'h0, 4'h0, 4'h0, 4'hF);
        end
      endcase
    end

    // Mid-slot reset: slot 32 is digit 0 (shows F, not blanked); drop rst_n in cycle 3.
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_an", {28'd0, an}, 32'hE);
    chk("pre_reset_seg", {25'd0, seg}, {25'd0, ~HEX[15]});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {28'd0, an}, 32'hF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_dp", {31'd0, dp}, 32'd1);
    chk("async_rst_frame", {31'd0, frame_done}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    release_reset();
    for (int s = 0; s < 8; s++) run_slot(1'b0, 0, 16'h0, 4'h0, 4'h0, 4'hF);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_seven_seg_scan.md
# multi_seven_seg_scan

Parametrised time-multiplexed driver for a common-anode seven-segment display with NUM_DIGITS digits. It holds a coherent shadow copy of all digit values, loaded by a one-cycle strobe. It scans one digit per refresh slot and decodes full hex (0-F) to active-low segments. It sits between the application datapath and the board display pins, replacing the fixed four-digit scanner with a configurable digit count, refresh rate, per-digit blanking, optional brightness PWM and a frame marker.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 2..8.
- DIV_COUNT, 100000: clk cycles per digit slot; legal minimum 4.
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  hex value per digit; digit i is [4i+3:4i], digit 0 is rightmost.
- dots  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank  in  NUM_DIGITS  per-digit blank request, 1 = digit dark.
- load  in  1  one-cycle strobe; captures digits/dots/blank into shadow registers.
- brightness  in  4  PWM duty code; used only when the macro is defined.
- an  out  NUM_DIGITS  anodes, active-low, one-hot-low or all high.
- seg  out  7  {ca,cb,cc,cd,ce,cf,cg}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at the start of each full scan.

## Operation
- Shadow registers are written on every rising edge where load=1. When load=0 they hold. The display uses only shadow values, so inputs may change freely between strobes.
- Prescaler pcnt counts 0..DIV_COUNT-1 and wraps. Digit index idx advances on the wrap, going 0,1,...,NUM_DIGITS-1,0.
- Slot start is the edge where pcnt wraps. On that edge, seg and dp are registered from shadow[idx_next]. They hold unchanged for the whole slot, so mid-slot loads cause no glitches.
- Segment encoding is abcdefg active-high, then inverted:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- If a digit's shadow blank bit is 1: seg=7'h7F, dp=1 and its anode stays high for the whole slot. The slot time is still consumed.
- dp is the inverse of the shadow dot bit for the scanned digit.
- Anode ghost guard: in slot cycle 0 all anodes are high. In cycles 1..ON-1, an[idx]=0 and the other anodes are high. With the macro undefined, ON=DIV_COUNT.
- frame_done=1 for exactly the first cycle of every slot with idx=0.

## Timing
- Reset values: an all ones, seg 7'h7F, dp 1, frame_done 0, pcnt 0, idx 0.
- Shadow reset values: digits 0, dots 0, blank all ones. The display stays dark until the first load.
- After rst_n deasserts, the first slot (idx 0) starts immediately. frame_done is not pulsed for this first slot; the first pulse comes NUM_DIGITS*DIV_COUNT cycles after release.
- Load latency:
  - A load captured during slot k affects the display from the next slot of that digit.
  - If the load edge coincides with a slot start, the new slot uses the old shadow values.
- Scan period is NUM_DIGITS*DIV_COUNT cycles, exactly, with no drift.
- Reset mid-slot: all outputs return to reset values asynchronously, and the shadow registers are cleared.

## Configuration
- BRIGHTNESS_PWM_EN defined:
  - ON = ((brightness+1)*DIV_COUNT) >> 4, clamped to at least 1.
  - brightness=15 gives full slot on-time less the guard cycle; brightness giving ON=1 gives a dark display.
  - brightness is sampled at each slot start and held for that slot.
- BRIGHTNESS_PWM_EN undefined: ON=DIV_COUNT, the brightness port is ignored, and no PWM comparator is built.

## Test plan
- Bench configuration for all scenarios: NUM_DIGITS=4, DIV_COUNT=8.
- Reset, then no load -> an=4'b1111, seg=7'h7F, dp=1 for 64+ cycles; first frame_done pulse 32 cycles after rst_n release.
- Load digits=16'h1A3F, dots=4'b0100, blank=0 -> slots show:
  - digit0: seg=~7'h47, dp=1
  - digit1: seg=~7'h79, dp=1
  - digit2: seg=~7'h77, dp=0
  - digit3: seg=~7'h30, dp=1
  - anodes low in slot cycles 1..7 only; frame_done pulses every 32 cycles.
- Load blank=4'b1010 -> an[1] and an[3] never go low; seg=7'h7F during their slots; the other digits are unchanged.
- Change digits and pulse load at slot cycle 4 of digit 2 -> seg constant for the rest of that slot; the new value appears on the next digit-2 slot.
- Assert rst_n low at slot cycle 3 -> outputs return to reset values in the same cycle without waiting for clk; shadow cleared; display dark after release.
- With BRIGHTNESS_PWM_EN defined:
  - brightness=7 (ON=4) -> anode low for cycles 1..3 only.
  - brightness=1 (ON=1) -> anode never low.
